execute_alu: RTL and testbench

EXECUTE_ALU -- requirements
Module: execute_alu

---
 rtl/alu_pkg.sv | 74 +++++++
 rtl/div_unit.sv | 113 +++++++++++
 rtl/execute_alu.sv | 202 ++++++++++++++++++++
 tb/tb_execute_alu.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the decode stage and the execute ALU:
//   - 6-bit op-code constants carried on alu_control (0 = no-op)
//   - FSM state type and state constants for the execute block
//   - small op-classification helpers and a 32->64 sign-extension helper
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [5:0] OP_NOP    = 6'd0;
    localparam logic [5:0] OP_ADDI   = 6'd1;
    localparam logic [5:0] OP_SLTI   = 6'd2;
    localparam logic [5:0] OP_SLTIU  = 6'd3;
    localparam logic [5:0] OP_XORI   = 6'd4;
    localparam logic [5:0] OP_ORI    = 6'd5;
    localparam logic [5:0] OP_ANDI   = 6'd6;
    localparam logic [5:0] OP_SLLI   = 6'd7;
    localparam logic [5:0] OP_SRLI   = 6'd8;
    localparam logic [5:0] OP_SRAI   = 6'd9;
    localparam logic [5:0] OP_ADD    = 6'd12;
    localparam logic [5:0] OP_SUB    = 6'd13;
    localparam logic [5:0] OP_SLL    = 6'd14;
    localparam logic [5:0] OP_SLT    = 6'd15;
    localparam logic [5:0] OP_SLTU   = 6'd16;
    localparam logic [5:0] OP_XOR    = 6'd17;
    localparam logic [5:0] OP_SRL    = 6'd18;
    localparam logic [5:0] OP_SRA    = 6'd19;
    localparam logic [5:0] OP_OR     = 6'd20;
    localparam logic [5:0] OP_AND    = 6'd21;
    localparam logic [5:0] OP_ADDIW  = 6'd22;
    localparam logic [5:0] OP_SLLIW  = 6'd23;
    localparam logic [5:0] OP_SRLIW  = 6'd24;
    localparam logic [5:0] OP_SRAIW  = 6'd25;
    localparam logic [5:0] OP_ADDW   = 6'd26;
    localparam logic [5:0] OP_SUBW   = 6'd27;
    localparam logic [5:0] OP_SLLW   = 6'd28;
    localparam logic [5:0] OP_SRLW   = 6'd29;
    localparam logic [5:0] OP_SRAW   = 6'd30;
    localparam logic [5:0] OP_MUL    = 6'd31;
    localparam logic [5:0] OP_MULH   = 6'd32;
    localparam logic [5:0] OP_MULHSU = 6'd33;
    localparam logic [5:0] OP_MULHU  = 6'd34;
    localparam logic [5:0] OP_DIV    = 6'd35;
    localparam logic [5:0] OP_DIVU   = 6'd36;
    localparam logic [5:0] OP_REM    = 6'd37;
    localparam logic [5:0] OP_REMU   = 6'd38;
    localparam logic [5:0] OP_MULW   = 6'd39;
    localparam logic [5:0] OP_DIVW   = 6'd40;
    localparam logic [5:0] OP_DIVUW  = 6'd41;
    localparam logic [5:0] OP_REMW   = 6'd42;
    localparam logic [5:0] OP_REMUW  = 6'd43;

    // Execute-block FSM state
    typedef logic [1:0] aluState_t;
    localparam aluState_t IDLE = 2'd0;
    localparam aluState_t DIV  = 2'd1;
    localparam aluState_t DONE = 2'd2;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Op codes 10, 11 and 44..63 are unassigned; 0 is the no-op
    function automatic logic isValidOp(input logic [5:0] op);
        return ((op >= OP_ADDI) && (op <= OP_SRAI)) ||
               ((op >= OP_ADD) && (op <= OP_REMUW));
    endfunction

    function automatic logic isDivOp(input logic [5:0] op);
        return ((op >= OP_DIV) && (op <= OP_REMU)) ||
               ((op >= OP_DIVW) && (op <= OP_REMUW));
    endfunction

endpackage

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Iterative restoring divider, one quotient bit per clock.
// Operands are converted to magnitudes at start; signs are reapplied on the
// way out. Word ops place the 32-bit magnitude in the top half of the shift
// register so only 32 iterations are needed.
// Ports:
//   clk, reset        clock, synchronous active-high reset (aborts a run)
//   start             load operands and begin (ignored while busy)
//   isSigned/isWord   signed select, 32-bit (W) select
//   isRem             1 = return remainder, 0 = quotient
//   dividend/divisor  64-bit operands (W uses bits [31:0]); divisor != 0
//   busy              iteration in progress
//   done              high during the cycle that performs the final iteration
//   result            final value, valid from the cycle after done until the
//                     next start
// -----------------------------------------------------------------------------
module div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        isSigned,
    input  logic        isWord,
    input  logic        isRem,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [63:0] result
);

    logic [63:0] quoReg;
    logic [63:0] remReg;
    logic [63:0] divisorReg;
    logic [5:0]  countReg;
    logic        busyReg;
    logic        wordReg;
    logic        remSelReg;
    logic        negQuoReg;
    logic        negRemReg;

    logic        aNeg;
    logic        bNeg;
    logic [63:0] aMag;
    logic [63:0] bMag;
    logic [31:0] aMag32;
    logic [31:0] bMag32;
    logic [64:0] remShift;
    logic        fits;
    logic [63:0] remSub;
    logic [63:0] quoFixed;
    logic [63:0] remFixed;
    logic [63:0] selected;

    assign aNeg   = isSigned && (isWord ? dividend[31] : dividend[63]);
    assign bNeg   = isSigned && (isWord ? divisor[31]  : divisor[63]);
    assign aMag   = aNeg ? -dividend : dividend;
    assign bMag   = bNeg ? -divisor  : divisor;
    assign aMag32 = aNeg ? -dividend[31:0] : dividend[31:0];
    assign bMag32 = bNeg ? -divisor[31:0]  : divisor[31:0];

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // When it fits the difference is below the divisor, so 64 bits suffice.
    assign remShift = {remReg, quoReg[63]};
    assign fits     = remShift >= {1'b0, divisorReg};
    assign remSub   = remShift[63:0] - divisorReg;

    assign busy = busyReg;
    assign done = busyReg && (countReg == (wordReg ? 6'd31 : 6'd63));

    // Quotient negative when operand signs differ; remainder takes the
    // dividend's sign.
    assign quoFixed = negQuoReg ? -quoReg : quoReg;
    assign remFixed = negRemReg ? -remReg : remReg;
    assign selected = remSelReg ? remFixed : quoFixed;
    assign result   = wordReg ? sext32(selected[31:0]) : selected;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            quoReg     <= '0;
            remReg     <= '0;
            divisorReg <= '0;
            countReg   <= '0;
            busyReg    <= 1'b0;
            wordReg    <= 1'b0;
            remSelReg  <= 1'b0;
            negQuoReg  <= 1'b0;
            negRemReg  <= 1'b0;
        end else if (start && !busyReg) begin
            quoReg     <= isWord ? {aMag32, 32'd0} : aMag;
            remReg     <= '0;
            divisorReg <= isWord ? {32'd0, bMag32} : bMag;
            countReg   <= '0;
            busyReg    <= 1'b1;
            wordReg    <= isWord;
            remSelReg  <= isRem;
            negQuoReg  <= aNeg ^ bNeg;
            negRemReg  <= aNeg;
        end else if (busyReg) begin
            quoReg   <= {quoReg[62:0], fits};
            remReg   <= fits ? remSub : remShift[63:0];
            countReg <= countReg + 6'd1;
            if (done) begin
                busyReg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/execute_alu.sv
// -----------------------------------------------------------------------------
// execute_alu
// Execute stage: single-cycle integer ALU and multiplier, plus an iterative
// divider for div/rem ops. Single-cycle ops (and divides by zero / signed
// overflow) return their result one cycle after acceptance; real divides
// run through IDLE -> DIV -> DONE and return after 64 (W: 32) iterations.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   in_valid/in_ready  op handshake; inputs sampled when both high
//   alu_control        op code (0 = no-op)
//   addressC           destination register
//   rs1_data/rs2_data  operand A / register operand B
//   imm, muxB_control  immediate; 1 selects imm as operand B
//   out_valid          one-cycle result pulse
//   out_addr/out_data  writeback register and result, held until next result
//   out_we             write enable, qualified by out_valid
// -----------------------------------------------------------------------------
module execute_alu
    import alu_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [5:0]                alu_control,
    input  logic [4:0]                addressC,
    input  logic [BUS_DATA_WIDTH-1:0] rs1_data,
    input  logic [BUS_DATA_WIDTH-1:0] rs2_data,
    input  logic [BUS_DATA_WIDTH-1:0] imm,
    input  logic                      muxB_control,
    output logic                      out_valid,
    output logic [4:0]                out_addr,
    output logic [BUS_DATA_WIDTH-1:0] out_data,
    output logic                      out_we
);

    aluState_t   stateReg;
    logic        validReg;
    logic        weReg;
    logic [4:0]  addrReg;
    logic [63:0] dataReg;
    logic [4:0]  pendAddrReg;
    logic        pendWeReg;

    logic [63:0]  opB;
    logic [5:0]   sh64;
    logic [4:0]   sh32;
    logic [31:0]  a32;
    logic [31:0]  b32;
    logic [31:0]  sraW;
    logic         extA;
    logic         extB;
    logic [127:0] product;
    logic         divOp;
    logic         divWord;
    logic         divSigned;
    logic         divRem;
    logic         divZero;
    logic         divOvf;
    logic [63:0]  dividendExt;
    logic [63:0]  aluResult;
    logic         accept;
    logic         startDiv;
    logic         writeEn;
    logic         divBusy;
    logic         divDone;
    logic [63:0]  divResult;

    assign opB  = muxB_control ? imm : rs2_data;
    assign sh64 = opB[5:0];
    assign sh32 = opB[4:0];
    assign a32  = rs1_data[31:0];
    assign b32  = opB[31:0];
    assign sraW = $signed(a32) >>> sh32;

    // One 128-bit multiplier serves the whole mul family: the low half is
    // sign-agnostic, the high half depends on how each operand is extended.
    assign extA    = ((alu_control == OP_MULH) || (alu_control == OP_MULHSU)) ? rs1_data[63] : 1'b0;
    assign extB    = (alu_control == OP_MULH) ? opB[63] : 1'b0;
    assign product = {{64{extA}}, rs1_data} * {{64{extB}}, opB};

    assign divOp     = isDivOp(alu_control);
    assign divWord   = alu_control >= OP_DIVW;
    assign divSigned = (alu_control == OP_DIV)  || (alu_control == OP_REM) ||
                       (alu_control == OP_DIVW) || (alu_control == OP_REMW);
    assign divRem    = (alu_control == OP_REM)  || (alu_control == OP_REMU) ||
                       (alu_control == OP_REMW) || (alu_control == OP_REMUW);
    assign divZero   = divWord ? (b32 == 32'd0) : (opB == 64'd0);
    assign divOvf    = divSigned && (divWord ?
                       ((a32 == 32'h8000_0000) && (b32 == 32'hFFFF_FFFF)) :
                       ((rs1_data == 64'h8000_0000_0000_0000) && (opB == 64'hFFFF_FFFF_FFFF_FFFF)));
    assign dividendExt = divWord ? sext32(a32) : rs1_data;

    always_comb begin
        aluResult = 64'd0;
        case (alu_control)
            OP_ADDI, OP_ADD:   aluResult = rs1_data + opB;
            OP_SUB:            aluResult = rs1_data - opB;
            OP_SLTI, OP_SLT:   aluResult = {63'd0, $signed(rs1_data) < $signed(opB)};
            OP_SLTIU, OP_SLTU: aluResult = {63'd0, rs1_data < opB};
            OP_XORI, OP_XOR:   aluResult = rs1_data ^ opB;
            OP_ORI, OP_OR:     aluResult = rs1_data | opB;
            OP_ANDI, OP_AND:   aluResult = rs1_data & opB;
            OP_SLLI, OP_SLL:   aluResult = rs1_data << sh64;
            OP_SRLI, OP_SRL:   aluResult = rs1_data >> sh64;
            OP_SRAI, OP_SRA:   aluResult = $signed(rs1_data) >>> sh64;
            OP_ADDIW, OP_ADDW: aluResult = sext32(a32 + b32);
            OP_SUBW:           aluResult = sext32(a32 - b32);
            OP_SLLIW, OP_SLLW: aluResult = sext32(a32 << sh32);
            OP_SRLIW, OP_SRLW: aluResult = sext32(a32 >> sh32);
            OP_SRAIW, OP_SRAW: aluResult = sext32(sraW);
            OP_MUL:            aluResult = product[63:0];
            OP_MULH, OP_MULHSU, OP_MULHU: aluResult = product[127:64];
            OP_MULW:           aluResult = sext32(product[31:0]);
            // Only the one-cycle divide special cases produce a value here;
            // ordinary divides take their result from the divider.
            OP_DIV, OP_DIVU, OP_REM, OP_REMU,
            OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW: begin
                if (divZero) begin
                    aluResult = divRem ? dividendExt : 64'hFFFF_FFFF_FFFF_FFFF;
                end else if (divOvf) begin
                    aluResult = divRem ? 64'd0 : dividendExt;
                end
            end
            default:           aluResult = 64'd0;
        endcase
    end

    assign in_ready = (stateReg != DIV);
    assign accept   = in_valid && in_ready;
    assign startDiv = accept && divOp && !divZero && !divOvf;
    assign writeEn  = isValidOp(alu_control) && (addressC != 5'd0);

    div_unit u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (startDiv),
        .isSigned (divSigned),
        .isWord   (divWord),
        .isRem    (divRem),
        .dividend (rs1_data),
        .divisor  (opB),
        .busy     (divBusy),
        .done     (divDone),
        .result   (divResult)
    );

    // In DONE the divider result is presented directly, then captured into
    // the holding registers on the way back to IDLE.
    assign out_valid = validReg || (stateReg == DONE);
    assign out_data  = (stateReg == DONE) ? divResult : dataReg;
    assign out_addr  = (stateReg == DONE) ? pendAddrReg : addrReg;
    assign out_we    = (stateReg == DONE) ? pendWeReg : (weReg && validReg);

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg    <= IDLE;
            validReg    <= 1'b0;
            weReg       <= 1'b0;
            addrReg     <= 5'd0;
            dataReg     <= 64'd0;
            pendAddrReg <= 5'd0;
            pendWeReg   <= 1'b0;
        end else begin
            validReg <= 1'b0;
            case (stateReg)
                DIV: begin
                    if (divDone) begin
                        stateReg <= DONE;
                    end else if (!divBusy) begin
                        // Divider lost its run; never strand the pipeline.
                        stateReg <= IDLE;
                    end
                end
                DONE: begin
                    stateReg <= IDLE;
                    dataReg  <= divResult;
                    addrReg  <= pendAddrReg;
                    weReg    <= pendWeReg;
                end
                default: stateReg <= IDLE;
            endcase
            // An op accepted in DONE overrides the capture above: its own
            // result is the next one to be shown.
            if (accept) begin
                if (startDiv) begin
                    stateReg    <= DIV;
                    pendAddrReg <= addressC;
                    pendWeReg   <= writeEn;
                end else begin
                    validReg <= 1'b1;
                    dataReg  <= aluResult;
                    addrReg  <= addressC;
                    weReg    <= writeEn;
                end
            end
        end
    end

endmodule

// File: tb/tb_execute_alu.sv
// -----------------------------------------------------------------------------
// tb_execute_alu
// Directed tests for execute_alu with hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_execute_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  alu_control;
    logic [4:0]  addressC;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic [63:0] imm;
    logic        muxB_control;
    logic        out_valid;
    logic [4:0]  out_addr;
    logic [63:0] out_data;
    logic        out_we;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    execute_alu #(.BUS_DATA_WIDTH(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_control  (alu_control),
        .addressC     (addressC),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .imm          (imm),
        .muxB_control (muxB_control),
        .out_valid    (out_valid),
        .out_addr     (out_addr),
        .out_data     (out_data),
        .out_we       (out_we)
    );

    // Directed single-cycle vectors: op, muxB, A, B (imm when muxB=1), expected
    localparam int NV = 14;
    logic [5:0]  vOp  [NV] = '{6'd13, 6'd15, 6'd16, 6'd9, 6'd8, 6'd14, 6'd28,
                               6'd25, 6'd31, 6'd39, 6'd33, 6'd4, 6'd29, 6'd3};
    logic        vMux [NV] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                               1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [63:0] vA   [NV] = '{64'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                               64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd1, 64'd1,
                               64'h0000_0000_8000_0000, 64'd3, 64'h0000_0000_0001_0000,
                               64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_00F0,
                               64'hFFFF_FFFF_8000_0000, 64'd5};
    logic [63:0] vB   [NV] = '{64'd3, 64'd1, 64'd1, 64'd4, 64'd4, 64'd65, 64'd31,
                               64'd36, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0001_0000,
                               64'd2, 64'h0000_0000_0000_00FF, 64'd4, 64'd6};
    logic [63:0] vExp [NV] = '{64'd7, 64'd1, 64'd0, 64'hF800_0000_0000_0000,
                               64'h0800_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_8000_0000,
                               64'hFFFF_FFFF_F800_0000, 64'hFFFF_FFFF_FFFF_FFFA, 64'd0,
                               64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_000F,
                               64'h0000_0000_0800_0000, 64'd1};

    // Present one op for exactly one accepting edge; returns at the sample
    // point of the cycle after acceptance.
    task automatic issue(input logic [5:0] op, input logic [4:0] rd,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] immv, input logic muxB);
        @(negedge clk);
        alu_control  = op;
        addressC     = rd;
        rs1_data     = a;
        rs2_data     = b;
        imm          = immv;
        muxB_control = muxB;
        in_valid     = 1'b1;
        @(negedge clk);
        in_valid     = 1'b0;
    endtask

    // Latency in cycles after acceptance (0 if no result within maxCyc) and
    // the number of sampled cycles with in_ready low before the result.
    task automatic waitResult(input string name, input int maxCyc,
                              output int lat, output int lowCnt);
        lat    = 0;
        lowCnt = 0;
        for (int k = 1; k <= maxCyc; k++) begin
            if (!in_ready) lowCnt++;
            if (out_valid) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        $display("txn %s: latency=%0d ready_low=%0d addr=%0d data=%h we=%b",
                 name, lat, lowCnt, out_addr, out_data, out_we);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if ({out_valid, out_we, out_addr, out_data, in_ready} !== {1'b0, 1'b0, 5'd0, 64'd0, 1'b1}) begin
            mismatched++;
            $display("FAIL reset_state: got valid=%b we=%b addr=%0d data=%h ready=%b, required 0 0 0 0 1",
                     out_valid, out_we, out_addr, out_data, in_ready);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_addi();
        int lat, low;
        issue(6'd1, 5'd7, 64'd5, 64'hDEAD, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
        waitResult("addi", 5, lat, low);
        compared++;
        if ({lat, out_addr, out_data, out_we} !== {32'd1, 5'd7, 64'd2, 1'b1}) begin
            mismatched++;
            $display("FAIL addi: got lat=%0d addr=%0d data=%h we=%b, required 1 7 2 1",
                     lat, out_addr, out_data, out_we);
        end
        @(negedge clk);
        compared++;
        if ({out_valid, out_data, out_addr} !== {1'b0, 64'd2, 5'd7}) begin
            mismatched++;
            $display("FAIL addi_hold: got valid=%b data=%h addr=%0d, required 0 2 7",
                     out_valid, out_data, out_addr);
        end
    endtask

    task automatic test_addw();
        int lat, low;
        issue(6'd26, 5'd3, 64'h0000_0000_7FFF_FFFF, 64'd1, 64'd0, 1'b0);
        waitResult("addw", 5, lat, low);
        compared++;
        if ({lat, out_data} !== {32'd1, 64'hFFFF_FFFF_8000_0000}) begin
            mismatched++;
            $display("FAIL addw: got lat=%0d data=%h, required 1 ffffffff80000000", lat, out_data);
        end
    endtask

    task automatic test_alu_ops();
        int lat, low;
        for (int i = 0; i < NV; i++) begin
            if (vMux[i])
                issue(vOp[i], 5'd9, vA[i], 64'h5555_AAAA_5555_AAAA, vB[i], 1'b1);
            else
                issue(vOp[i], 5'd9, vA[i], vB[i], 64'h5555_AAAA_5555_AAAA, 1'b0);
            waitResult($sformatf("op%0d", vOp[i]), 5, lat, low);
            compared++;
            if ({lat, out_data, out_we, out_addr} !== {32'd1, vExp[i], 1'b1, 5'd9}) begin
                mismatched++;
                $display("FAIL alu_op%0d: got lat=%0d data=%h we=%b addr=%0d, required 1 %h 1 9",
                         vOp[i], lat, out_data, out_we, out_addr, vExp[i]);
            end
        end
    endtask

    task automatic test_write_enable();
        int lat, low;
        logic [5:0] ops [3] = '{6'd0, 6'd10, 6'd12};
        logic [4:0] rds [3] = '{5'd5, 5'd5, 5'd0};
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], rds[i], 64'd2, 64'd3, 64'd0, 1'b0);
            waitResult($sformatf("we_op%0d_rd%0d", ops[i], rds[i]), 5, lat, low);
            compared++;
            if ({lat, out_we} !== {32'd1, 1'b0}) begin
                mismatched++;
                $display("FAIL write_enable_%0d: got lat=%0d we=%b, required 1 0", i, lat, out_we);
            end
        end
    endtask

    task automatic test_mul_high();
        int lat, low;
        issue(6'd32, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
        waitResult("mulh", 5, lat, low);
        compared++;
        if ({lat, out_data} !== {32'd1, 64'd0}) begin
            mismatched++;
            $display("FAIL mulh: got lat=%0d data=%h, required 1 0", lat, out_data);
        end
        issue(6'd34, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
        waitResult("mulhu", 5, lat, low);
        compared++;
        if ({lat, out_data} !== {32'd1, 64'hFFFF_FFFF_FFFF_FFFE}) begin
            mismatched++;
            $display("FAIL mulhu: got lat=%0d data=%h, required 1 fffffffffffffffe", lat, out_data);
        end
    endtask

    task automatic test_divide();
        int lat, low;
        issue(6'd35, 5'd10, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'd0, 1'b0);
        waitResult("div", 200, lat, low);
        compared++;
        if ({lat, low, out_data, out_addr, out_we} !== {32'd65, 32'd64, 64'hFFFF_FFFF_FFFF_FFFA, 5'd10, 1'b1}) begin
            mismatched++;
            $display("FAIL div: got lat=%0d ready_low=%0d data=%h addr=%0d we=%b, required 65 64 fffffffffffffffa 10 1",
                     lat, low, out_data, out_addr, out_we);
        end
        @(negedge clk);
        compared++;
        if ({out_valid, out_data, in_ready} !== {1'b0, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1}) begin
            mismatched++;
            $display("FAIL div_hold: got valid=%b data=%h ready=%b, required 0 fffffffffffffffa 1",
                     out_valid, out_data, in_ready);
        end
        issue(6'd37, 5'd11, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'd0, 1'b0);
        waitResult("rem", 200, lat, low);
        compared++;
        if ({lat, out_data} !== {32'd65, 64'hFFFF_FFFF_FFFF_FFFE}) begin
            mismatched++;
            $display("FAIL rem: got lat=%0d data=%h, required 65 fffffffffffffffe", lat, out_data);
        end
    endtask

    task automatic test_divide_word();
        int lat, low;
        issue(6'd40, 5'd12, 64'h1234_5678_FFFF_FFEC, 64'd3, 64'd0, 1'b0);
        waitResult("divw", 200, lat, low);
        compared++;
        if ({lat, low, out_data} !== {32'd33, 32'd32, 64'hFFFF_FFFF_FFFF_FFFA}) begin
            mismatched++;
            $display("FAIL divw: got lat=%0d ready_low=%0d data=%h, required 33 32 fffffffffffffffa",
                     lat, low, out_data);
        end
        issue(6'd43, 5'd12, 64'h0000_0000_0000_0011, 64'h0000_0001_0000_0005, 64'd0, 1'b0);
        waitResult("remuw", 200, lat, low);
        compared++;
        if ({lat, out_data} !== {32'd33, 64'd2}) begin
            mismatched++;
            $display("FAIL remuw: got lat=%0d data=%h, required 33 2", lat, out_data);
        end
    endtask

    task automatic test_div_by_zero();
        int lat, low;
        issue(6'd36, 5'd13, 64'd123, 64'd0, 64'd0, 1'b0);
        waitResult("divu0", 200, lat, low);
        compared++;
        if ({lat, out_data} !== {32'd1, 64'hFFFF_FFFF_FFFF_FFFF}) begin
            mismatched++;
            $display("FAIL divu_zero: got lat=%0d data=%h, required 1 ffffffffffffffff", lat, out_data);
        end
        issue(6'd38, 5'd13, 64'd123, 64'd0, 64'd0, 1'b0);
        waitResult("remu0", 200, lat, low);
        compared++;
        if ({lat, out_data} !== {32'd1, 64'd123}) begin
            mismatched++;
            $display("FAIL remu_zero: got lat=%0d data=%h, required 1 7b", lat, out_data);
        end
        issue(6'd42, 5'd13, 64'h0000_0000_8000_0010, 64'h0000_0007_0000_0000, 64'd0, 1'b0);
        waitResult("remw0", 200, lat, low);
        compared++;
        if ({lat, out_data} !== {32'd1, 64'hFFFF_FFFF_8000_0010}) begin
            mismatched++;
            $display("FAIL remw_zero: got lat=%0d data=%h, required 1 ffffffff80000010", lat, out_data);
        end
    endtask

    task automatic test_overflow();
        int lat, low;
        issue(6'd35, 5'd14, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
        waitResult("div_ovf", 200, lat, low);
        compared++;
        if ({lat, out_data} !== {32'd1, 64'h8000_0000_0000_0000}) begin
            mismatched++;
            $display("FAIL div_overflow: got lat=%0d data=%h, required 1 8000000000000000", lat, out_data);
        end
        issue(6'd37, 5'd14, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
        waitResult("rem_ovf", 200, lat, low);
        compared++;
        if ({lat, out_data} !== {32'd1, 64'd0}) begin
            mismatched++;
            $display("FAIL rem_overflow: got lat=%0d data=%h, required 1 0", lat, out_data);
        end
        issue(6'd40, 5'd14, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 1'b0);
        waitResult("divw_ovf", 200, lat, low);
        compared++;
        if ({lat, out_data} !== {32'd1, 64'hFFFF_FFFF_8000_0000}) begin
            mismatched++;
            $display("FAIL divw_overflow: got lat=%0d data=%h, required 1 ffffffff80000000", lat, out_data);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        alu_control = 6'd12; addressC = 5'd1; rs1_data = 64'd1; rs2_data = 64'd1;
        muxB_control = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        $display("txn b2b_first: valid=%b addr=%0d data=%h", out_valid, out_addr, out_data);
        compared++;
        if ({out_valid, out_addr, out_data} !== {1'b1, 5'd1, 64'd2}) begin
            mismatched++;
            $display("FAIL b2b_first: got valid=%b addr=%0d data=%h, required 1 1 2",
                     out_valid, out_addr, out_data);
        end
        addressC = 5'd2; rs1_data = 64'd2; rs2_data = 64'd2;
        @(negedge clk);
        in_valid = 1'b0;
        $display("txn b2b_second: valid=%b addr=%0d data=%h", out_valid, out_addr, out_data);
        compared++;
        if ({out_valid, out_addr, out_data} !== {1'b1, 5'd2, 64'd4}) begin
            mismatched++;
            $display("FAIL b2b_second: got valid=%b addr=%0d data=%h, required 1 2 4",
                     out_valid, out_addr, out_data);
        end
        @(negedge clk);
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_idle: got valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_reset_abort();
        int lat, low;
        int pulses = 0;
        issue(6'd35, 5'd15, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'd0, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        $display("txn reset_abort: valid=%b ready=%b data=%h", out_valid, in_ready, out_data);
        compared++;
        if ({out_valid, in_ready, out_we, out_data} !== {1'b0, 1'b1, 1'b0, 64'd0}) begin
            mismatched++;
            $display("FAIL reset_abort: got valid=%b ready=%b we=%b data=%h, required 0 1 0 0",
                     out_valid, in_ready, out_we, out_data);
        end
        repeat (70) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        compared++;
        if (pulses !== 0) begin
            mismatched++;
            $display("FAIL reset_abort_pulse: got %0d result pulses, required 0", pulses);
        end
        issue(6'd12, 5'd4, 64'd2, 64'd3, 64'd0, 1'b0);
        waitResult("add_after_abort", 5, lat, low);
        compared++;
        if ({lat, out_data, out_addr} !== {32'd1, 64'd5, 5'd4}) begin
            mismatched++;
            $display("FAIL add_after_abort: got lat=%0d data=%h addr=%0d, required 1 5 4",
                     lat, out_data, out_addr);
        end
    endtask

    initial begin
        reset        = 1'b1;
        in_valid     = 1'b0;
        alu_control  = 6'd0;
        addressC     = 5'd0;
        rs1_data     = 64'd0;
        rs2_data     = 64'd0;
        imm          = 64'd0;
        muxB_control = 1'b0;

        test_reset();
        test_addi();
        test_addw();
        test_alu_ops();
        test_write_enable();
        test_mul_high();
        test_divide();
        test_divide_word();
        test_div_by_zero();
        test_overflow();
        test_back_to_back();
        test_reset_abort();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", compared);
        $fatal(1, "watchdog");
    end

endmodule
